// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID-stage operand/hazard bundle between the decode stage (master) and fwd_hazard_ctrl (slave)
interface fwd_hazard_ctrl_if #(
  parameter int rfWidth = 3,
  parameter int opForwardSelWidth = 2,
  parameter int CNT_WIDTH = 16
);
  logic [rfWidth-1:0] idRs;
  logic [rfWidth-1:0] idRt;
  logic idUseRs;
  logic idUseRt;
  logic [rfWidth-1:0] idDest;
  logic idRegWrite;
  logic idMemRead;
  logic flush;
  logic freeze;
  logic [opForwardSelWidth-1:0] selA;
  logic [opForwardSelWidth-1:0] selB;
  logic stall;
  logic [CNT_WIDTH-1:0] stallCount;
  modport master (
    output idRs, idRt, idUseRs, idUseRt, idDest, idRegWrite, idMemRead, flush, freeze,
    input selA, selB, stall, stallCount
  );
  modport slave (
    input idRs, idRt, idUseRs, idUseRt, idDest, idRegWrite, idMemRead, flush, freeze,
    output selA, selB, stall, stallCount
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX/MEM/WB dest tracking, operand forward selects (ID=0 EX=1 MEM=2 WB=3), load-use stall and saturating stall counter
module fwd_hazard_ctrl #(
  parameter int rfWidth = 3,
  parameter int opForwardSelWidth = 2,
  parameter int ZERO_REG_HARD = 1,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  fwd_hazard_ctrl_if.slave bus
);
  localparam logic [opForwardSelWidth-1:0] SEL_ID = opForwardSelWidth'(0);
  localparam logic [opForwardSelWidth-1:0] SEL_EX = opForwardSelWidth'(1);
  localparam logic [opForwardSelWidth-1:0] SEL_MEM = opForwardSelWidth'(2);
  localparam logic [opForwardSelWidth-1:0] SEL_WB = opForwardSelWidth'(3);
  typedef logic [rfWidth-1:0] reg_t;
  logic v_ex_q, v_ex_d, l_ex_q, l_ex_d, v_mem_q, v_mem_d, v_wb_q, v_wb_d;
  reg_t d_ex_q, d_ex_d, d_mem_q, d_mem_d, d_wb_q, d_wb_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0] hit_a, hit_b;
  logic stall, bubble;
  function automatic logic match(input logic v, input reg_t d, input reg_t r);
    return v && d == r && !(ZERO_REG_HARD != 0 && r == '0);
  endfunction
  always_comb begin
    hit_a = {3{bus.idUseRs}} & {match(v_ex_q, d_ex_q, bus.idRs), match(v_mem_q, d_mem_q, bus.idRs), match(v_wb_q, d_wb_q, bus.idRs)};
    hit_b = {3{bus.idUseRt}} & {match(v_ex_q, d_ex_q, bus.idRt), match(v_mem_q, d_mem_q, bus.idRt), match(v_wb_q, d_wb_q, bus.idRt)};
    stall = l_ex_q && (hit_a[2] || hit_b[2]);
    bubble = stall || bus.flush;
    v_ex_d = bus.freeze ? v_ex_q : !bubble && bus.idRegWrite;
    l_ex_d = bus.freeze ? l_ex_q : !bubble && bus.idMemRead;
    d_ex_d = bus.freeze ? d_ex_q : bubble ? '0 : bus.idDest;
    v_mem_d = bus.freeze ? v_mem_q : v_ex_q;
    d_mem_d = bus.freeze ? d_mem_q : d_ex_q;
    v_wb_d = bus.freeze ? v_wb_q : v_mem_q;
    d_wb_d = bus.freeze ? d_wb_q : d_mem_q;
    cnt_d = (!bus.freeze && stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  assign bus.selA = hit_a[2] ? SEL_EX : hit_a[1] ? SEL_MEM : hit_a[0] ? SEL_WB : SEL_ID;
  assign bus.selB = hit_b[2] ? SEL_EX : hit_b[1] ? SEL_MEM : hit_b[0] ? SEL_WB : SEL_ID;
  assign bus.stall = stall;
  assign bus.stallCount = cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_ex_q <= 1'b0;
      l_ex_q <= 1'b0;
      d_ex_q <= '0;
      v_mem_q <= 1'b0;
      d_mem_q <= '0;
      v_wb_q <= 1'b0;
      d_wb_q <= '0;
      cnt_q <= '0;
    end else begin
      v_ex_q <= v_ex_d;
      l_ex_q <= l_ex_d;
      d_ex_q <= d_ex_d;
      v_mem_q <= v_mem_d;
      d_mem_q <= d_mem_d;
      v_wb_q <= v_wb_d;
      d_wb_q <= d_wb_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed scoreboard bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic s;
    logic [CW-1:0] c;
  } exp_t;
  exp_t eq[$];
  string tq[$];
  fwd_hazard_ctrl_if #(.rfWidth(3), .opForwardSelWidth(2), .CNT_WIDTH(CW)) bus ();
  fwd_hazard_ctrl #(.rfWidth(3), .opForwardSelWidth(2), .ZERO_REG_HARD(1), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input string tag, input logic [2:0] rs, input logic urs, input logic [2:0] rt,
                       input logic urt, input logic [2:0] dest, input logic rw, input logic mr,
                       input logic fl, input logic fz, input logic [1:0] ea, input logic [1:0] eb,
                       input logic es, input logic [CW-1:0] ec);
    bus.idRs = rs;
    bus.idUseRs = urs;
    bus.idRt = rt;
    bus.idUseRt = urt;
    bus.idDest = dest;
    bus.idRegWrite = rw;
    bus.idMemRead = mr;
    bus.flush = fl;
    bus.freeze = fz;
    eq.push_back('{a: ea, b: eb, s: es, c: ec});
    tq.push_back(tag);
  endtask
  task automatic expect_now(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                            input logic es, input logic [CW-1:0] ec);
    eq.push_back('{a: ea, b: eb, s: es, c: ec});
    tq.push_back(tag);
  endtask
  task automatic chk();
    exp_t e;
    string t;
    if (eq.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = eq.pop_front();
      t = tq.pop_front();
      cmp({t, ".selA"}, 32'(bus.selA), 32'(e.a));
      cmp({t, ".selB"}, 32'(bus.selB), 32'(e.b));
      cmp({t, ".stall"}, 32'(bus.stall), 32'(e.s));
      cmp({t, ".stallCount"}, 32'(bus.stallCount), 32'(e.c));
    end
  endtask
  task automatic step(input string tag, input logic [2:0] rs, input logic urs, input logic [2:0] rt,
                      input logic urt, input logic [2:0] dest, input logic rw, input logic mr,
                      input logic fl, input logic fz, input logic [1:0] ea, input logic [1:0] eb,
                      input logic es, input logic [CW-1:0] ec);
    drive(tag, rs, urs, rt, urt, dest, rw, mr, fl, fz, ea, eb, es, ec);
    @(negedge clk);
    chk();
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive("rst_hold", 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk();
    @(posedge clk);
    #1 rst = 1'b0;
    //            tag          rs urs rt urt dst rw mr fl fz  A  B  S  C
    step("rst_rel",     3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("alu_prod",    0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    step("alu_ex",      2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("alu_mem",     2, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    step("alu_wb",      2, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    step("alu_ret",     2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("pri_p1",      0, 0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step("pri_p2",      0, 0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step("pri_p3",      0, 0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step("pri_ex",      0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("pri_mem",     0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    step("pri_wb",      0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    step("mix_p1",      0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("mix_p2",      0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    step("mix",         1, 1, 6, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0);
    step("mix_nouse",   1, 0, 6, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    step("drain1",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("ld_prod",     0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0);
    step("ld_stall",    4, 1, 0, 0, 7, 1, 0, 0, 0, 1, 0, 1, 0);
    step("ld_resolve",  4, 1, 0, 0, 7, 1, 0, 0, 0, 2, 0, 0, 1);
    step("ld_after",    7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step("drain2",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("drain3",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("z_prod",      0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    step("z_use",       0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("z_ld",        0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    step("z_ld_use",    0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("drain4",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("fz_ld",       0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 1);
    step("fz_stall1",   3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    step("fz_stall2",   3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    step("fz_stall3",   3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    step("fz_rel",      3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    step("fz_res",      3, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 2);
    step("drain5",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step("fl_prod",     0, 0, 0, 0, 6, 1, 0, 1, 0, 0, 0, 0, 2);
    step("fl_use",      6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step("fs_ld",       0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 2);
    step("fs_both",     2, 1, 0, 0, 5, 1, 0, 1, 0, 1, 0, 1, 2);
    step("fs_after",    5, 1, 2, 1, 0, 0, 0, 0, 0, 0, 2, 0, 3);
    step("drain6",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    step("rm_ld",       0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 3);
    drive("rm_stall",   1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3);
    @(negedge clk);
    chk();
    #1 rst = 1'b1;
    expect_now("rm_rst", 0, 0, 0, 0);
    #1 chk();
    @(posedge clk);
    #1 rst = 1'b0;
    drive("sat_fill",   4, 1, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0);
    void'(eq.pop_back());
    void'(tq.pop_back());
    for (int i = 0; i < 2 * ((1 << CW) + 5); i++) begin
      @(posedge clk);
    end
    #1;
    step("sat_a",       4, 1, 0, 0, 4, 1, 1, 0, 0, 2, 0, 0, 8'hFF);
    step("sat_b",       4, 1, 0, 0, 4, 1, 1, 0, 0, 1, 0, 1, 8'hFF);
    step("sat_c",       4, 1, 0, 0, 4, 1, 1, 0, 0, 2, 0, 0, 8'hFF);
    if (eq.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", eq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
